// File: rtl/p405s_dcu_plb_pkg.sv
// rtl/p405s_dcu_plb_pkg.sv - shared types and helpers for the DCU PLB write-data buffer
//
// Purpose: transfer FSM state type, byte width, load-source select codes and
// the per-byte odd-parity helper used when DCU_PLBWR_PARITY_EN is defined.
// Ports: none (package).

package p405s_dcu_plb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    XFER = 2'd2
  } wr_state_e;

  localparam int BYTE_W = 8;

  localparam logic SRC_FDR = 1'b0;
  localparam logic SRC_SDP = 1'b1;

  // Odd parity: the returned bit makes the total count of ones (byte + bit) odd.
  function automatic logic odd_par(input logic [BYTE_W-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/p405s_dcu_plb_wr_lane.sv
// rtl/p405s_dcu_plb_wr_lane.sv - one byte lane of the write-buffer merge register
//
// Purpose: selects FDR or SDP byte (or the mirrored low-slot byte) and holds
// the previous merge value when the lane is not enabled.
// Ports:
//   i_cb, i_reset_l  clock / synchronous active-low reset
//   i_en             capture enable (beat accepted and byte enabled)
//   i_sel            source select (SRC_FDR / SRC_SDP)
//   i_mirror         take i_mirror_byte instead of the selected source
//   i_fdr, i_sdp     candidate source bytes
//   i_mirror_byte    next value of the matching byte in word slot 0
//   o_d              next merge value of this lane (pushed into the FIFO)

module p405s_dcu_plb_wr_lane
  import p405s_dcu_plb_pkg::*;
(
  input  logic              i_cb,
  input  logic              i_reset_l,
  input  logic              i_en,
  input  logic              i_sel,
  input  logic              i_mirror,
  input  logic [BYTE_W-1:0] i_fdr,
  input  logic [BYTE_W-1:0] i_sdp,
  input  logic [BYTE_W-1:0] i_mirror_byte,
  output logic [BYTE_W-1:0] o_d
);

  logic [BYTE_W-1:0] r_q;
  logic [BYTE_W-1:0] w_src;
  logic [BYTE_W-1:0] w_cap;

  always_comb begin
    w_src = i_fdr;
    case (i_sel)
      SRC_FDR: w_src = i_fdr;
      SRC_SDP: w_src = i_sdp;
    endcase
    w_cap = i_mirror ? i_mirror_byte : w_src;
    o_d   = i_en ? w_cap : r_q;
  end

  always_ff @(posedge i_cb) begin
    if (!i_reset_l) begin
      r_q <= '0;
    end else begin
      r_q <= o_d;
    end
  end

endmodule

// File: rtl/p405s_dcu_plb_wr_buf.sv
// rtl/p405s_dcu_plb_wr_buf.sv - DCU PLB write-data buffer: byte-merge register feeding a beat FIFO
//
// Purpose: merges FDR line data or replicated SDP store data per byte into a
// merge register, pushes each accepted beat into a DEPTH-entry FIFO on the
// same edge, and presents the FIFO head to the PLB until write-data ack.
// Optional feature macro: DCU_PLBWR_PARITY_EN (per-byte odd parity stored
// with each beat, checked against plbParChk on ack, sticky DCU_wrParErr).
// Ports:
//   CB, resetL                  clock / synchronous active-low reset
//   ldValid/ldReady             load handshake
//   ldSel, ldMirror, ldByteEn   source select, low-slot mirror, byte capture enables
//   ldLast                      final beat of transfer
//   FDR_L2mux, SDP_dataL2       line data / store data
//   plbWrDAck, plbWrAbort       PLB head-beat ack / transfer abort
//   DCU_plbDBus, DCU_plbBE      head beat data / byte enables
//   DCU_plbWrReq                head beat valid
//   DCU_wrBufCnt                occupied entries
//   plbParChk, DCU_plbDBusPar, DCU_wrParErr   parity build only

module p405s_dcu_plb_wr_buf
  import p405s_dcu_plb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SDP_W  = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     CB,
  input  logic                     resetL,
  input  logic                     ldValid,
  output logic                     ldReady,
  input  logic                     ldSel,
  input  logic                     ldMirror,
  input  logic [DATA_W/8-1:0]      ldByteEn,
  input  logic                     ldLast,
  input  logic [DATA_W-1:0]        FDR_L2mux,
  input  logic [SDP_W-1:0]         SDP_dataL2,
  input  logic                     plbWrDAck,
  input  logic                     plbWrAbort,
`ifdef DCU_PLBWR_PARITY_EN
  input  logic [DATA_W/8-1:0]      plbParChk,
  output logic [DATA_W/8-1:0]      DCU_plbDBusPar,
  output logic                     DCU_wrParErr,
`endif
  output logic [DATA_W-1:0]        DCU_plbDBus,
  output logic [DATA_W/8-1:0]      DCU_plbBE,
  output logic                     DCU_plbWrReq,
  output logic [$clog2(DEPTH):0]   DCU_wrBufCnt
);

  localparam int NB  = DATA_W / BYTE_W;
  localparam int BPS = SDP_W / BYTE_W;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  wr_state_e         r_state;
  wr_state_e         w_state_nxt;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [NB-1:0]     r_mem_be   [DEPTH];

  logic              w_full;
  logic              w_wrreq;
  logic              w_ack;
  logic              w_accept;
  logic [SDP_W-1:0]        w_d_lo;
  logic [DATA_W-SDP_W-1:0] w_d_hi;
  logic [DATA_W-1:0]       w_push_data;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_wrreq = (r_count != '0) && (r_state != IDLE);
  assign w_ack   = plbWrDAck && w_wrreq && !plbWrAbort;

  // A full buffer still takes a beat when the head is being acked in the
  // same cycle, so the ack path feeds ldReady combinationally.
  assign ldReady  = (r_state != XFER) && (!w_full || (plbWrDAck && w_wrreq));
  assign w_accept = ldValid && ldReady && !plbWrAbort;

  // Slot-0 lanes produce w_d_lo; higher lanes read it for mirroring. Keeping
  // the two halves in separate nets keeps the mirror path acyclic.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [BYTE_W-1:0] w_mir_byte;
    logic              w_mir_en;
    logic [BYTE_W-1:0] w_d;

    if (gi < BPS) begin : g_lo
      assign w_mir_byte = '0;
      assign w_mir_en   = 1'b0;
      assign w_d_lo[gi*BYTE_W +: BYTE_W] = w_d;
    end else begin : g_hi
      assign w_mir_byte = w_d_lo[(gi % BPS)*BYTE_W +: BYTE_W];
      assign w_mir_en   = ldMirror;
      assign w_d_hi[(gi-BPS)*BYTE_W +: BYTE_W] = w_d;
    end

    p405s_dcu_plb_wr_lane u_lane (
      .i_cb          (CB),
      .i_reset_l     (resetL),
      .i_en          (w_accept && ldByteEn[gi]),
      .i_sel         (ldSel),
      .i_mirror      (w_mir_en),
      .i_fdr         (FDR_L2mux[gi*BYTE_W +: BYTE_W]),
      .i_sdp         (SDP_dataL2[(gi % BPS)*BYTE_W +: BYTE_W]),
      .i_mirror_byte (w_mir_byte),
      .o_d           (w_d)
    );
  end

  assign w_push_data = {w_d_hi, w_d_lo};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = ldLast ? XFER : FILL;
      FILL: if (w_accept && ldLast) w_state_nxt = XFER;
      XFER: if (w_ack && (r_count == CW'(1))) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (plbWrAbort) w_state_nxt = IDLE;
  end

  always_ff @(posedge CB) begin
    if (!resetL) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (plbWrAbort) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_ack)    r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_accept) - CW'(w_ack);
    end
  end

  always_ff @(posedge CB) begin
    if (w_accept) begin
      r_mem_data[r_wr_ptr] <= w_push_data;
      r_mem_be[r_wr_ptr]   <= ldByteEn;
    end
  end

  // Outputs read zero whenever nothing is pending, which also gives the
  // cleared DBus/BE after reset or abort.
  assign DCU_plbDBus  = w_wrreq ? r_mem_data[r_rd_ptr] : '0;
  assign DCU_plbBE    = w_wrreq ? r_mem_be[r_rd_ptr]   : '0;
  assign DCU_plbWrReq = w_wrreq;
  assign DCU_wrBufCnt = r_count;

`ifdef DCU_PLBWR_PARITY_EN
  logic [NB-1:0] r_mem_par [DEPTH];
  logic [NB-1:0] w_push_par;
  logic          r_par_err;

  always_comb begin
    w_push_par = '0;
    for (int i = 0; i < NB; i++) begin
      w_push_par[i] = odd_par(w_push_data[i*BYTE_W +: BYTE_W]);
    end
  end

  always_ff @(posedge CB) begin
    if (w_accept) r_mem_par[r_wr_ptr] <= w_push_par;
  end

  // Checked only when the PLB actually takes the head beat; sticky until reset.
  always_ff @(posedge CB) begin
    if (!resetL) begin
      r_par_err <= 1'b0;
    end else if (w_ack && (plbParChk != r_mem_par[r_rd_ptr])) begin
      r_par_err <= 1'b1;
    end
  end

  assign DCU_plbDBusPar = w_wrreq ? r_mem_par[r_rd_ptr] : '0;
  assign DCU_wrParErr   = r_par_err;
`endif

endmodule

// File: tb/tb_p405s_dcu_plb_wr_buf.sv
// tb/tb_p405s_dcu_plb_wr_buf.sv - self-checking bench for p405s_dcu_plb_wr_buf

module tb_p405s_dcu_plb_wr_buf;

  localparam int DATA_W = 64;
  localparam int SDP_W  = 32;
  localparam int DEPTH  = 4;
  localparam int NB     = DATA_W / 8;
  localparam int BPS    = SDP_W / 8;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_XFER = 2;

  logic CB = 1'b0;
  always #5 CB = ~CB;

  logic              resetL = 1'b0;
  logic              ldValid = 1'b0;
  logic              ldSel = 1'b0;
  logic              ldMirror = 1'b0;
  logic [NB-1:0]     ldByteEn = '0;
  logic              ldLast = 1'b0;
  logic [DATA_W-1:0] FDR_L2mux = '0;
  logic [SDP_W-1:0]  SDP_dataL2 = '0;
  logic              plbWrDAck = 1'b0;
  logic              plbWrAbort = 1'b0;
  logic              ldReady;
  logic [DATA_W-1:0] DCU_plbDBus;
  logic [NB-1:0]     DCU_plbBE;
  logic              DCU_plbWrReq;
  logic [CW-1:0]     DCU_wrBufCnt;
`ifdef DCU_PLBWR_PARITY_EN
  logic [NB-1:0]     plbParChk = '0;
  logic [NB-1:0]     DCU_plbDBusPar;
  logic              DCU_wrParErr;
`endif

  p405s_dcu_plb_wr_buf #(.DATA_W(DATA_W), .SDP_W(SDP_W), .DEPTH(DEPTH)) dut (
    .CB           (CB),
    .resetL       (resetL),
    .ldValid      (ldValid),
    .ldReady      (ldReady),
    .ldSel        (ldSel),
    .ldMirror     (ldMirror),
    .ldByteEn     (ldByteEn),
    .ldLast       (ldLast),
    .FDR_L2mux    (FDR_L2mux),
    .SDP_dataL2   (SDP_dataL2),
    .plbWrDAck    (plbWrDAck),
    .plbWrAbort   (plbWrAbort),
`ifdef DCU_PLBWR_PARITY_EN
    .plbParChk    (plbParChk),
    .DCU_plbDBusPar (DCU_plbDBusPar),
    .DCU_wrParErr (DCU_wrParErr),
`endif
    .DCU_plbDBus  (DCU_plbDBus),
    .DCU_plbBE    (DCU_plbBE),
    .DCU_plbWrReq (DCU_plbWrReq),
    .DCU_wrBufCnt (DCU_wrBufCnt)
  );

  // Behavioural model: queue of pending beats, merge image, transfer phase.
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [NB-1:0]     be;
  } beat_t;

  beat_t             q[$];
  int                m_state = M_IDLE;
  logic [DATA_W-1:0] m_mrg = '0;
  bit                m_perr = 1'b0;
  bit                par_flip = 1'b0;
  bit                chk_on = 1'b0;
  int                n_vec = 0;
  int                n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_wrreq();
    return (q.size() != 0) && (m_state != M_IDLE);
  endfunction

  function automatic bit m_ready();
    return (m_state != M_XFER) && ((q.size() < DEPTH) || (plbWrDAck && m_wrreq()));
  endfunction

  function automatic beat_t m_head();
    beat_t h;
    h = '0;
    if (m_wrreq()) h = q[0];
    return h;
  endfunction

  function automatic logic [NB-1:0] m_par(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ~^d[i*8 +: 8];
    return p;
  endfunction

  task automatic m_step();
    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] nb;
    bit acc;
    bit ackd;
    if (!resetL) begin
      q.delete();
      m_state = M_IDLE;
      m_mrg   = '0;
      m_perr  = 1'b0;
      return;
    end
    if (plbWrAbort) begin
      q.delete();
      m_state = M_IDLE;
      return;
    end
    acc  = ldValid && m_ready();
    ackd = plbWrDAck && m_wrreq();
    src  = ldSel ? {(DATA_W/SDP_W){SDP_dataL2}} : FDR_L2mux;
    nb   = m_mrg;
    for (int b = 0; b < BPS; b++)
      if (ldByteEn[b]) nb[b*8 +: 8] = src[b*8 +: 8];
    // Mirrored upper bytes copy the already-updated low word.
    for (int b = BPS; b < NB; b++)
      if (ldByteEn[b]) nb[b*8 +: 8] = ldMirror ? nb[(b % BPS)*8 +: 8] : src[b*8 +: 8];
    if (ackd) begin
      if (par_flip) m_perr = 1'b1;
      void'(q.pop_front());
    end
    if (acc) begin
      m_mrg = nb;
      q.push_back(beat_t'{d: nb, be: ldByteEn});
    end
    if (acc && m_state == M_IDLE) m_state = ldLast ? M_XFER : M_FILL;
    else if (acc && m_state == M_FILL && ldLast) m_state = M_XFER;
    else if (m_state == M_XFER && q.size() == 0) m_state = M_IDLE;
  endtask

  always @(negedge CB) begin
    if (chk_on) begin
      chk("wrreq", DCU_plbWrReq, m_wrreq());
      chk("count", DCU_wrBufCnt, q.size());
      chk("dbus",  DCU_plbDBus,  m_head().d);
      chk("be",    DCU_plbBE,    m_head().be);
      chk("ready", ldReady,      m_ready());
`ifdef DCU_PLBWR_PARITY_EN
      chk("dbuspar", DCU_plbDBusPar, m_wrreq() ? m_par(m_head().d) : '0);
      chk("parerr",  DCU_wrParErr,   m_perr);
`endif
    end
  end

  task automatic cyc(input bit v, input bit sel, input bit mir, input logic [NB-1:0] be,
                     input bit last, input logic [DATA_W-1:0] fdr, input logic [SDP_W-1:0] sdp,
                     input bit ack, input bit abt);
    ldValid = v; ldSel = sel; ldMirror = mir; ldByteEn = be; ldLast = last;
    FDR_L2mux = fdr; SDP_dataL2 = sdp; plbWrDAck = ack; plbWrAbort = abt;
`ifdef DCU_PLBWR_PARITY_EN
    plbParChk = m_par(m_head().d) ^ {NB{par_flip}};
`endif
    @(posedge CB);
    m_step();
    #1;
  endtask

  task automatic idle(input bit ack);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, ack, 1'b0);
  endtask

  task automatic fdr_beat(input logic [DATA_W-1:0] d, input logic [NB-1:0] be, input bit last, input bit ack);
    cyc(1'b1, 1'b0, 1'b0, be, last, d, '0, ack, 1'b0);
  endtask

  initial begin
    logic [7:0] bb;

    resetL = 1'b0;
    idle(1'b0);
    idle(1'b0);
    resetL = 1'b1;
    chk("rst_wrreq", DCU_plbWrReq, 1'b0);
    chk("rst_cnt",   DCU_wrBufCnt, 0);
    chk("rst_dbus",  DCU_plbDBus, 64'h0);
    chk("rst_be",    DCU_plbBE, 8'h00);
    chk("rst_ready", ldReady, 1'b1);
    chk_on = 1'b1;

    // single mirrored store
    cyc(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, '0, 32'hA1B2C3D4, 1'b0, 1'b0);
    chk("t1_dbus",  DCU_plbDBus, 64'hA1B2C3D4A1B2C3D4);
    chk("t1_be",    DCU_plbBE, 8'hFF);
    chk("t1_wrreq", DCU_plbWrReq, 1'b1);
    chk("t1_ready_xfer", ldReady, 1'b0);
    idle(1'b1);
    chk("t1_wrreq_done", DCU_plbWrReq, 1'b0);
    chk("t1_cnt_done", DCU_wrBufCnt, 0);

    // mirror from FDR, then partial mirror holding upper bytes
    cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 64'hDEADBEEF01234567, '0, 1'b0, 1'b0);
    chk("t1b_dbus", DCU_plbDBus, 64'h0123456701234567);
    idle(1'b1);
    cyc(1'b1, 1'b1, 1'b1, 8'h0F, 1'b1, '0, 32'h55667788, 1'b0, 1'b0);
    chk("t1c_dbus", DCU_plbDBus, 64'h0123456755667788);
    chk("t1c_be",   DCU_plbBE, 8'h0F);
    idle(1'b1);

    // line burst to full, then in-order drain
    for (int k = 1; k <= 4; k++) begin
      bb = 8'(17 * k);
      fdr_beat({8{bb}}, 8'hFF, k == 4, 1'b0);
    end
    chk("t2_cnt_full", DCU_wrBufCnt, 4);
    chk("t2_ready_full", ldReady, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      bb = 8'(17 * k);
      chk("t2_head", DCU_plbDBus, {8{bb}});
      idle(1'b1);
      chk("t2_cnt", DCU_wrBufCnt, 4 - k);
    end

    // byte merge across beats
    fdr_beat(64'h0102030405060708, 8'h0F, 1'b0, 1'b0);
    chk("t3_first", DCU_plbDBus, 64'h4444444405060708);
    chk("t3_first_be", DCU_plbBE, 8'h0F);
    fdr_beat(64'hA0B0C0D0E0F01020, 8'hF0, 1'b1, 1'b0);
    idle(1'b1);
    chk("t3_merged", DCU_plbDBus, 64'hA0B0C0D005060708);
    chk("t3_merged_be", DCU_plbBE, 8'hF0);
    idle(1'b1);

    // full with push and ack in the same cycle
    for (int k = 1; k <= 4; k++) begin
      bb = 8'(8'hA0 + k);
      fdr_beat({8{bb}}, 8'hFF, 1'b0, 1'b0);
    end
    chk("t4_ready_full", ldReady, 1'b0);
    fdr_beat({8{8'hA5}}, 8'hFF, 1'b1, 1'b1);
    chk("t4_cnt_same", DCU_wrBufCnt, 4);
    for (int k = 2; k <= 5; k++) begin
      bb = 8'(8'hA0 + k);
      chk("t4_head", DCU_plbDBus, {8{bb}});
      idle(1'b1);
    end
    chk("t4_cnt_empty", DCU_wrBufCnt, 0);

    // abort in FILL with two entries; aborted beat must not reach the merge reg
    fdr_beat({8{8'hB1}}, 8'hFF, 1'b0, 1'b0);
    fdr_beat({8{8'hB2}}, 8'hFF, 1'b0, 1'b0);
    chk("t5_cnt2", DCU_wrBufCnt, 2);
    cyc(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, {8{8'hCC}}, '0, 1'b1, 1'b1);
    chk("t5_cnt0", DCU_wrBufCnt, 0);
    chk("t5_wrreq", DCU_plbWrReq, 1'b0);
    chk("t5_be", DCU_plbBE, 8'h00);
    idle(1'b1);
    chk("t5_ack_ign", DCU_wrBufCnt, 0);
    fdr_beat({8{8'h5A}}, 8'h01, 1'b1, 1'b0);
    chk("t5_after", DCU_plbDBus, 64'hB2B2B2B2B2B2B25A);
    idle(1'b1);

    // reset in the middle of a transfer
    fdr_beat({8{8'hD1}}, 8'hFF, 1'b0, 1'b0);
    fdr_beat({8{8'hD2}}, 8'hFF, 1'b0, 1'b0);
    resetL = 1'b0;
    idle(1'b0);
    resetL = 1'b1;
    chk("t6_cnt", DCU_wrBufCnt, 0);
    idle(1'b1);
    idle(1'b1);
    chk("t6_wrreq", DCU_plbWrReq, 1'b0);

    // mixed vectors checked against the model
    for (int i = 0; i < 80; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          NB'($urandom), $urandom_range(0, 3) == 0, {$urandom, $urandom}, $urandom,
          1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1'b0);

`ifdef DCU_PLBWR_PARITY_EN
    fdr_beat(64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b0);
    par_flip = 1'b1;
    idle(1'b1);
    par_flip = 1'b0;
    chk("t7_err_set", DCU_wrParErr, 1'b1);
    idle(1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("t7_err_sticky", DCU_wrParErr, 1'b1);
    resetL = 1'b0;
    idle(1'b0);
    resetL = 1'b1;
    chk("t7_err_clr", DCU_wrParErr, 1'b0);
`endif

    idle(1'b0);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
